// File: rtl/da_fir_param.sv
// Parameterised distributed-arithmetic FIR filter: NGRP groups of K taps, each
// group served by a 2**K-entry coefficient LUT, one input bit processed per cycle.
module da_fir_param #(
  parameter  int NGRP = 2,
  parameter  int K    = 4,
  parameter  int IW   = 8,
  parameter  int CW   = 20,
  localparam int OW   = CW + IW + $clog2(NGRP),
  localparam int AW   = $clog2(NGRP) + K
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [IW-1:0] x_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 cload,
  input  logic [AW-1:0]        caddr,
  input  logic signed [CW-1:0] cin,
  output logic signed [OW-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int N  = NGRP * K;
  localparam int BW = (IW > 1) ? $clog2(IW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t                 state;
  logic signed [IW-1:0]   tap [N];
  logic signed [CW-1:0]   lut [NGRP*(1<<K)];
  logic signed [OW-1:0]   acc;
  logic signed [OW-1:0]   s_sum;
  logic signed [OW-1:0]   term;
  logic [BW-1:0]          b;
  logic                   fin;
  logic [K-1:0]           addr [NGRP];
  logic [AW-1:0]          idx  [NGRP];

  assign busy     = (state != IDLE);
  assign in_ready = (state == IDLE) && !cload;

  // Each group's LUT address gathers bit b of its K taps; the group outputs are summed.
  always_comb begin
    s_sum = '0;
    for (int g = 0; g < NGRP; g++) begin
      addr[g] = '0;
      for (int j = 0; j < K; j++) begin
        addr[g][j] = tap[g*K+j][b];
      end
      idx[g] = AW'(g * (1 << K)) | AW'(addr[g]);
      s_sum  = s_sum + OW'(lut[idx[g]]);
    end
    term = s_sum <<< b;
  end

  // Coefficient LUT is only writable while idle and is deliberately not reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && cload) begin
      lut[caddr] <= cin;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      b         <= '0;
      fin       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int n = 0; n < N; n++) begin
        tap[n] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !cload) begin
            for (int n = N - 1; n > 0; n--) begin
              tap[n] <= tap[n-1];
            end
            tap[0] <= x_in;
            acc    <= '0;
            b      <= '0;
            fin    <= 1'b0;
            state  <= CALC;
          end
        end
        CALC: begin
          // The sign-bit slice carries negative weight; one extra cycle registers the sum.
          if (!fin) begin
            if (b == BW'(IW - 1)) begin
              acc <= acc - term;
              fin <= 1'b1;
            end else begin
              acc <= acc + term;
              b   <= b + 1'b1;
            end
          end else begin
            out_data  <= acc;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_da_fir_param.sv
// Self-checking bench for da_fir_param: table-driven vectors checked through an
// expected-value queue, plus hand-written backpressure, load-conflict and reset sequences.
module tb_da_fir_param;

  localparam int OW = 29;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [7:0]    x_in;
  logic                 in_valid;
  logic                 in_ready;
  logic                 cload;
  logic [4:0]           caddr;
  logic signed [19:0]   cin;
  logic signed [OW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;

  da_fir_param dut (
    .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
    .cload(cload), .caddr(caddr), .cin(cin), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0]    x;
    logic signed [OW-1:0] exp;
    bit                   use_model;
  } vec_t;

  int                   checks = 0;
  int                   failures = 0;
  logic signed [OW-1:0] sbq[$];
  int                   hcur[8];
  int                   mtap[8];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [OW-1:0] modelOut();
    longint s = 0;
    for (int n = 0; n < 8; n++) s += longint'(hcur[n]) * longint'(mtap[n]);
    return OW'(s);
  endfunction

  task automatic shiftModel(input int x);
    for (int n = 7; n > 0; n--) mtap[n] = mtap[n-1];
    mtap[0] = x;
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
    for (int n = 0; n < 8; n++) mtap[n] = 0;
  endtask

  task automatic loadLut(input int h[8]);
    for (int n = 0; n < 8; n++) hcur[n] = h[n];
    for (int i = 0; i < 32; i++) begin
      int g = i / 16;
      int a = i % 16;
      int v = 0;
      for (int j = 0; j < 4; j++) if (((a >> j) & 1) == 1) v += h[g*4+j];
      cload = 1'b1;
      caddr = 5'(i);
      cin   = 20'(v);
      tick();
    end
    cload = 1'b0;
  endtask

  // Offers one sample, queues its expected result at the accept edge, then checks latency and data.
  task automatic applyStimulus(input logic signed [7:0] x, input logic signed [OW-1:0] expv,
                               input bit use_model, input string name,
                               output logic signed [OW-1:0] used);
    int k;
    x_in     = x;
    in_valid = 1'b1;
    k        = 0;
    #1;
    while (!in_ready && k < 20) begin
      tick();
      #1;
      k++;
    end
    if (k >= 20) checkOutput({name, "_accept_timeout"}, k, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    shiftModel(int'(x));
    used = use_model ? modelOut() : expv;
    sbq.push_back(used);
    checkOutput({name, "_busy"}, busy, 1);
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    checkOutput({name, "_latency"}, k, 9);
    checkOutput({name, "_valid"}, out_valid, 1);
    if (sbq.size() > 0) begin
      if (out_valid) checkOutput(name, out_data, sbq.pop_front());
      else void'(sbq.pop_front());
    end
    if (out_ready) begin
      tick();
      checkOutput({name, "_ack"}, out_valid, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t                 vecs[16];
    logic signed [OW-1:0] used;
    int                   seen;
    int h1[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int hs[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    int h2[8] = '{-100000, 77777, 12345, -1, 65536, -54321, 3, 99999};

    for (int i = 0; i < 16; i++) begin
      vecs[i].x         = (i == 0) ? 8'sd1 : 8'sd0;
      vecs[i].exp       = OW'(i + 1);
      vecs[i].use_model = 1'b0;
      if (i >= 8) begin
        vecs[i].x         = $signed(8'($urandom_range(0, 255)));
        vecs[i].exp       = '0;
        vecs[i].use_model = 1'b1;
      end
    end

    in_valid  = 1'b0;
    x_in      = '0;
    cload     = 1'b0;
    caddr     = '0;
    cin       = '0;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) mtap[n] = 0;
    doReset(2);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_in_ready", in_ready, 1);

    loadLut(h1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].x, vecs[i].exp, vecs[i].use_model, $sformatf("vec%0d", i), used);
    end

    // Output held under backpressure while a new sample is being offered.
    out_ready = 1'b0;
    applyStimulus(8'sd5, '0, 1'b1, "bp", used);
    in_valid = 1'b1;
    x_in     = 8'sd77;
    repeat (5) begin
      tick();
      checkOutput("bp_valid", out_valid, 1);
      checkOutput("bp_data", out_data, used);
      checkOutput("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    checkOutput("bp_release", out_valid, 0);
    checkOutput("bp_idle", busy, 0);
    applyStimulus(-8'sd3, '0, 1'b1, "bp_next", used);

    // LUT writes attempted mid-computation must be dropped.
    doReset(2);
    fork
      applyStimulus(8'sd1, 29'sd1, 1'b0, "calc_cload", used);
      begin
        repeat (3) @(posedge clk);
        #2;
        cload = 1'b1;
        caddr = 5'd1;
        cin   = 20'sd555;
        repeat (4) @(posedge clk);
        #2;
        cload = 1'b0;
      end
    join
    applyStimulus(8'sd3, '0, 1'b1, "after_calc_cload", used);

    // cload wins over in_valid in IDLE; the sample goes in on the following cycle.
    doReset(2);
    cload    = 1'b1;
    caddr    = 5'd1;
    cin      = 20'sd101;
    in_valid = 1'b1;
    x_in     = 8'sd1;
    #1;
    checkOutput("conflict_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    cload = 1'b0;
    checkOutput("conflict_not_accepted", busy, 0);
    applyStimulus(8'sd1, 29'sd101, 1'b0, "conflict_written", used);
    cload = 1'b1;
    caddr = 5'd1;
    cin   = 20'sd1;
    tick();
    cload = 1'b0;

    // Reset in the middle of CALC: no result, taps cleared, LUT kept.
    x_in     = 8'sd9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    checkOutput("midcalc_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 0; n < 8; n++) mtap[n] = 0;
    seen = 0;
    repeat (15) begin
      if (out_valid) seen++;
      tick();
    end
    checkOutput("midcalc_no_valid", seen, 0);
    checkOutput("midcalc_idle", busy, 0);
    applyStimulus(8'sd1, 29'sd1, 1'b0, "post_reset_impulse", used);

    loadLut(hs);
    applyStimulus(-8'sd128, -29'sd128, 1'b0, "sign_neg", used);
    applyStimulus(8'sd127, 29'sd127, 1'b0, "sign_pos", used);

    loadLut(h2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus($signed(8'($urandom_range(0, 255))), '0, 1'b1, $sformatf("wide%0d", i), used);
    end

    checkOutput("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/da_fir_param.md
DA_FIR_PARAM -- requirements
Module: da_fir_param

Interface
REQ-001 The block SHALL have parameter NGRP, default 2, meaning number of LUT groups.
REQ-002 The block SHALL have parameter K, default 4, meaning taps per group and LUT address width; total taps N = NGRP*K.
REQ-003 The block SHALL have parameter IW, default 8, meaning signed two's-complement sample width and bit-serial cycle count.
REQ-004 The block SHALL have parameter CW, default 20, meaning signed LUT entry width.
REQ-005 The block SHALL have derived parameter OW = CW+IW+clog2(NGRP), default 29, meaning signed output width.
REQ-006 The block SHALL have one clock; reset is synchronous and active-high.
REQ-007 The block SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-008 The block SHALL have port reset, input, 1, meaning the synchronous active-high reset.
REQ-009 The block SHALL have port x_in, input, IW, meaning the new signed sample.
REQ-010 The block SHALL have port in_valid, input, 1, meaning x_in is valid.
REQ-011 The block SHALL have port in_ready, output, 1, meaning the block accepts a sample this cycle.
REQ-012 The block SHALL have port cload, input, 1, meaning a LUT write request.
REQ-013 The block SHALL have port caddr, input, clog2(NGRP)+K, meaning {group index, entry index}.
REQ-014 The block SHALL have port cin, input, CW, meaning the signed LUT write data.
REQ-015 The block SHALL have port out_data, output, OW, meaning the signed filter result.
REQ-016 The block SHALL have port out_valid, output, 1, meaning out_data is valid.
REQ-017 The block SHALL have port out_ready, input, 1, meaning the consumer accepts out_data.
REQ-018 The block SHALL have port busy, output, 1, meaning the state is not IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, CALC and HOLD.
REQ-020 In IDLE, in_ready SHALL equal !cload; in_ready SHALL be 0 in CALC and HOLD.
REQ-021 On an IDLE cycle with in_valid=1 and in_ready=1, the block SHALL shift the N-tap delay line (tap[n] <= tap[n-1], tap[0] <= x_in), clear acc and the bit counter b, and go to CALC.
REQ-022 In IDLE with cload=1, the block SHALL write LUT[caddr group][caddr entry] <= cin; cload has priority over in_valid, and that sample is not accepted.
REQ-023 cload in CALC or HOLD SHALL be ignored, with no LUT change.
REQ-024 In CALC cycle b (0..IW-1), the address for group g SHALL have bit j = bit b of tap[g*K+j]; S = sum over g of LUT[g][addr], sign-extended.
REQ-025 In CALC, acc SHALL update as acc <= acc + (S<<b) for b<IW-1, and acc <= acc - (S<<(IW-1)) for b=IW-1 (sign bit).
REQ-026 After b=IW-1, the block SHALL register out_data <= final acc, set out_valid=1, and go to HOLD; latency SHALL be exactly IW+1 edges from the accept edge to out_valid visible.
REQ-027 In HOLD, out_data and out_valid SHALL stay stable until out_ready=1; on that edge out_valid <= 0 and the FSM goes to IDLE.
REQ-028 out_ready while out_valid=0 SHALL have no effect.
REQ-029 The result SHALL equal sum over n of h[n]*tap[n] when LUT[g][a] = sum of h[g*K+j] over the set bits j of a; no saturation, wrap at OW bits.
REQ-030 busy SHALL be 1 in CALC and HOLD, and 0 in IDLE.

Reset
REQ-031 Reset SHALL set state IDLE, clear all delay-line taps, and clear acc and b to 0.
REQ-032 Reset SHALL drive out_data=0, out_valid=0, busy=0 and in_ready=!cload.
REQ-033 LUT contents SHALL be retained through reset.
REQ-034 Reset asserted in CALC or HOLD SHALL abort the computation; no out_valid pulse results, and any pending result is discarded.

Verification
REQ-035 Reset test: assert reset for 2 cycles -> out_valid=0, out_data=0, busy=0, in_ready=1 on the first post-reset cycle.
REQ-036 Impulse test: load the LUT for h=[1..8] (defaults), send x=1 then seven zeros, out_ready=1 -> outputs 1,2,...,8, each 9 edges after its accept.
REQ-037 Sign test: h0=1, others 0, x=-128 -> out_data=-128; x=127 -> out_data=127.
REQ-038 Backpressure test: hold out_ready=0 for 5 cycles in HOLD with in_valid=1 -> out_data stable, in_ready=0, no sample accepted, one output after out_ready=1.
REQ-039 Load-conflict test: cload=1 during CALC -> LUT unchanged; cload=1 and in_valid=1 together in IDLE -> LUT written, in_ready=0, sample accepted next cycle.
REQ-040 Reset-mid-CALC test: reset at b=3 -> no out_valid; then impulse x=1 -> out_data=h0=1 (delay line cleared, LUT retained).
